// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic phase controller.
// Holds the phase state encoding, the two-digit BCD type, and the BCD helpers
// used both at elaboration (parameter conversion) and at run time (countdown).
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // One-step BCD decrement; 00 stays at 00 so the display can never show A..F.
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd0) begin
      if (v.tens != 4'd0) begin
        r.units = 4'd9;
        r.tens  = v.tens - 4'd1;
      end
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

  // Binary-to-BCD for the 0..99 time parameters, evaluated at elaboration.
  function automatic bcd2_t to_bcd(input int unsigned v);
    bcd2_t r;
    r.tens  = 4'((v / 10) % 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_bcd2_down_cntr.sv
// Two-digit BCD down counter with synchronous load, count enable and an
// is_one flag. Load has priority over enable; reset clears to 00.
module bcd2_down_cntr
  import traffic_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  bcd2_t load_val,
  input  logic  en,
  output bcd2_t value,
  output logic  is_one
);

  // Count register: reset, load or single BCD decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= bcd_dec(value);
    end
  end

  assign is_one = (value.tens == 4'd0) && (value.units == 4'd1);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light phase controller.
// Cycles GREEN -> YELLOW -> CLEAR per approach in round-robin order, skipping
// approaches with no waiting traffic, with early green timeout when the served
// approach is empty but others are waiting. The shared BCD display shows the
// remaining cycles of the current state (LOAD..1).
// Optional feature: define TRAFFIC_MANUAL_EN to enable the man/step manual
// hold of GREEN; without it man and step are ignored.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPROACH   = 2,
  parameter int GREEN_TIME   = 90,
  parameter int YELLOW_TIME  = 5,
  parameter int RED_TIME     = 1,
  parameter int EMPTY_CYCLES = 5,
  localparam int PW = (N_APPROACH <= 2) ? 1 : $clog2(N_APPROACH)
) (
  input  logic                  CLK,
  input  logic                  R,
  input  logic [N_APPROACH-1:0] traffic,
  input  logic                  man,
  input  logic                  step,
  output logic [N_APPROACH-1:0] green,
  output logic [N_APPROACH-1:0] yellow,
  output logic [3:0]            time_h,
  output logic [3:0]            time_l,
  output logic [PW-1:0]         phase
);

  localparam bcd2_t GREEN_BCD  = to_bcd(GREEN_TIME);
  localparam bcd2_t YELLOW_BCD = to_bcd(YELLOW_TIME);
  localparam bcd2_t RED_BCD    = to_bcd(RED_TIME);
  localparam logic [3:0] EMPTY_MAX = 4'(EMPTY_CYCLES);
  localparam logic [N_APPROACH-1:0] ONE_HOT0 = {{(N_APPROACH-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    empty_cnt;
  logic [3:0]    empty_nxt;
  logic          empty_hit;
  logic          others_waiting;
  logic [PW-1:0] next_app;
  logic [PW-1:0] phase_nxt;
  logic          enter_green;
  logic          hold;
  logic          step_go;

  logic          cnt_load;
  bcd2_t         cnt_load_val;
  logic          cnt_en;
  bcd2_t         cnt;
  logic          cnt_one;
  logic          cnt_zero;

`ifdef TRAFFIC_MANUAL_EN
  // Manual hold freezes GREEN only; YELLOW and CLEAR always stay timed.
  assign hold    = man && (state == ST_GREEN);
  assign step_go = hold && step;
`else
  logic unused_manual;
  assign unused_manual = man ^ step;
  assign hold          = 1'b0;
  assign step_go       = 1'b0;
`endif

  bcd2_down_cntr u_cntr (
    .clk      (CLK),
    .rst      (R),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .value    (cnt),
    .is_one   (cnt_one)
  );

  assign cnt_zero = (cnt.tens == 4'd0) && (cnt.units == 4'd0);
  assign time_h   = cnt.tens;
  assign time_l   = cnt.units;

  // Round-robin search starting after the current approach; the current one is
  // the last candidate, and with no traffic anywhere we simply advance by one.
  always_comb begin
    int idx;
    logic found;
    next_app = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N_APPROACH; i++) begin
      idx = (int'(phase) + i) % N_APPROACH;
      if (i == 1) next_app = PW'(idx);
      if (!found && traffic[PW'(idx)]) begin
        next_app = PW'(idx);
        found    = 1'b1;
      end
    end
  end

  // Empty-approach detector: served approach idle while someone else waits.
  always_comb begin
    others_waiting = |(traffic & ~(ONE_HOT0 << phase));
    if (!traffic[phase] && others_waiting) begin
      empty_nxt = (empty_cnt == EMPTY_MAX) ? EMPTY_MAX : empty_cnt + 4'd1;
    end else begin
      empty_nxt = 4'd0;
    end
    empty_hit = (empty_nxt == EMPTY_MAX);
  end

  // Phase sequencing and countdown load/enable decisions.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = GREEN_BCD;
    cnt_en       = 1'b0;
    enter_green  = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (cnt_one || cnt_zero) begin
          state_nxt   = ST_GREEN;
          cnt_load    = 1'b1;
          enter_green = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GREEN: begin
        if (step_go || (!hold && (cnt_one || empty_hit))) begin
          state_nxt    = ST_YELLOW;
          cnt_load     = 1'b1;
          cnt_load_val = YELLOW_BCD;
        end else if (!hold) begin
          cnt_en = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (cnt_one) begin
          cnt_load = 1'b1;
          if (RED_TIME == 0) begin
            state_nxt   = ST_GREEN;
            enter_green = 1'b1;
          end else begin
            state_nxt    = ST_CLEAR;
            cnt_load_val = RED_BCD;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_load  = 1'b1;
        cnt_load_val = '0;
      end
    endcase
  end

  assign phase_nxt = enter_green ? next_app : phase;

  // State, served approach and lamp registers; lamps track the next state so
  // they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (R) begin
      state  <= ST_CLEAR;
      phase  <= PW'(N_APPROACH - 1);
      green  <= '0;
      yellow <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      green  <= (state_nxt == ST_GREEN)  ? (ONE_HOT0 << phase_nxt) : '0;
      yellow <= (state_nxt == ST_YELLOW) ? (ONE_HOT0 << phase_nxt) : '0;
    end
  end

  // Empty counter: cleared on reset, outside GREEN and on every state entry;
  // frozen while manually held.
  always_ff @(posedge CLK) begin
    if (R) begin
      empty_cnt <= 4'd0;
    end else if ((state_nxt != state) || (state != ST_GREEN)) begin
      empty_cnt <= 4'd0;
    end else if (!hold) begin
      empty_cnt <= empty_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a default two-approach instance and a
// four-approach instance with short times and no all-red clearance.
module tb_traffic_phase_ctrl;

  localparam int EW = 19;

  logic CLK = 1'b0;
  logic R, R4;
  logic [1:0] traffic;
  logic [3:0] traffic4;
  logic man, step, man4, step4;

  logic [1:0] green, yellow;
  logic [3:0] time_h, time_l;
  logic       phase;
  logic [3:0] green4, yellow4;
  logic [3:0] time_h4, time_l4;
  logic [1:0] phase4;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl dut (
    .CLK(CLK), .R(R), .traffic(traffic), .man(man), .step(step),
    .green(green), .yellow(yellow), .time_h(time_h), .time_l(time_l),
    .phase(phase)
  );

  traffic_phase_ctrl #(
    .N_APPROACH(4), .GREEN_TIME(12), .YELLOW_TIME(3), .RED_TIME(0),
    .EMPTY_CYCLES(3)
  ) dut4 (
    .CLK(CLK), .R(R4), .traffic(traffic4), .man(man4), .step(step4),
    .green(green4), .yellow(yellow4), .time_h(time_h4), .time_l(time_l4),
    .phase(phase4)
  );

  // Clock
  always #5 CLK = ~CLK;

  function automatic logic [7:0] bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [1:0] g, input logic [1:0] y,
                       input int d, input logic ph);
    exp_q.push_back({1'b0, 2'b00, g, 2'b00, y, bcd(d), 1'b0, ph});
    name_q.push_back(nm);
  endtask

  task automatic chk_b(input string nm, input logic [3:0] g, input logic [3:0] y,
                       input int d, input logic [1:0] ph);
    exp_q.push_back({1'b1, g, y, bcd(d), ph});
    name_q.push_back(nm);
  endtask

  // Monitor: every expectation queued for this cycle is compared at negedge.
  logic [EW-1:0] e_v, a_v;
  string         e_nm;
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      e_v  = exp_q.pop_front();
      e_nm = name_q.pop_front();
      if (e_v[18] == 1'b0)
        a_v = {1'b0, 2'b00, green, 2'b00, yellow, time_h, time_l, 1'b0, phase};
      else
        a_v = {1'b1, green4, yellow4, time_h4, time_l4, phase4};
      checks++;
      if (a_v !== e_v) begin
        errors++;
        $display("FAIL %s @%0t: actual g=%b y=%b disp=%h ph=%0d, required g=%b y=%b disp=%h ph=%0d",
                 e_nm, $time, a_v[17:14], a_v[13:10], a_v[9:2], a_v[1:0],
                 e_v[17:14], e_v[13:10], e_v[9:2], e_v[1:0]);
      end
      checks++;
      if (a_v[9:6] > 4'd9 || a_v[5:2] > 4'd9) begin
        errors++;
        $display("FAIL %s_bcd @%0t: actual disp=%h, required BCD digits", e_nm, $time, a_v[9:2]);
      end
    end
  end

  initial begin
    R = 1'b1; R4 = 1'b1;
    traffic = 2'b00; traffic4 = 4'b0000;
    man = 1'b0; step = 1'b0; man4 = 1'b0; step4 = 1'b0;

    // Reset state, default instance
    cyc(); chk_a("rst_a", 2'b00, 2'b00, 0, 1'b1);
    cyc(); chk_a("rst_a", 2'b00, 2'b00, 0, 1'b1);
    R = 1'b0;

    // Full cycle with no traffic
    for (int d = 90; d >= 1; d--) begin cyc(); chk_a("green0", 2'b01, 2'b00, d, 1'b0); end
    for (int d = 5; d >= 1; d--)  begin cyc(); chk_a("yellow0", 2'b00, 2'b01, d, 1'b0); end
    cyc(); chk_a("clear0", 2'b00, 2'b00, 1, 1'b0);
    for (int d = 90; d >= 1; d--) begin cyc(); chk_a("green1", 2'b10, 2'b00, d, 1'b1); end
    for (int d = 5; d >= 3; d--)  begin cyc(); chk_a("yellow1", 2'b00, 2'b10, d, 1'b1); end

    // Reset mid-YELLOW
    R = 1'b1;
    cyc(); chk_a("rst_mid", 2'b00, 2'b00, 0, 1'b1);
    R = 1'b0;
    cyc(); chk_a("rst_release", 2'b01, 2'b00, 90, 1'b0);

    // Empty-approach early timeout
    traffic = 2'b10;
    for (int d = 89; d >= 86; d--) begin cyc(); chk_a("green0_empty", 2'b01, 2'b00, d, 1'b0); end
    cyc(); chk_a("empty_timeout", 2'b00, 2'b01, 5, 1'b0);
    for (int d = 4; d >= 1; d--)  begin cyc(); chk_a("yellow0_e", 2'b00, 2'b01, d, 1'b0); end
    cyc(); chk_a("clear0_e", 2'b00, 2'b00, 1, 1'b0);
    cyc(); chk_a("green1_e", 2'b10, 2'b00, 90, 1'b1);

    // Manual hold at display 70
    traffic = 2'b00;
    for (int d = 89; d >= 70; d--) begin cyc(); chk_a("green1_run", 2'b10, 2'b00, d, 1'b1); end
    man = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
`ifdef TRAFFIC_MANUAL_EN
      chk_a("man_hold", 2'b10, 2'b00, 70, 1'b1);
`else
      chk_a("man_ignored", 2'b10, 2'b00, 69 - k, 1'b1);
`endif
    end
    step = 1'b1;
    cyc();
`ifdef TRAFFIC_MANUAL_EN
    chk_a("man_step", 2'b00, 2'b10, 5, 1'b1);
`else
    chk_a("step_ignored", 2'b10, 2'b00, 49, 1'b1);
`endif
    step = 1'b0; man = 1'b0;
    cyc();
`ifdef TRAFFIC_MANUAL_EN
    chk_a("man_after", 2'b00, 2'b10, 4, 1'b1);
`else
    chk_a("man_after", 2'b10, 2'b00, 48, 1'b1);
`endif

    // Four-approach instance: reset state
    cyc(); chk_b("rst_b", 4'b0000, 4'b0000, 0, 2'd3);
    R4 = 1'b0;
    for (int d = 12; d >= 1; d--) begin cyc(); chk_b("b_green0", 4'b0001, 4'b0000, d, 2'd0); end
    for (int d = 3; d >= 1; d--)  begin cyc(); chk_b("b_yellow0", 4'b0000, 4'b0001, d, 2'd0); end
    // Skip approaches 1 and 2: only approach 3 waits at the end of YELLOW(0)
    traffic4 = 4'b1000;
    cyc(); chk_b("b_skip_to3", 4'b1000, 4'b0000, 12, 2'd3);
    // Approach 3 empty while 0 waits: timeout after EMPTY_CYCLES=3 edges
    traffic4 = 4'b0001;
    cyc(); chk_b("b_green3", 4'b1000, 4'b0000, 11, 2'd3);
    cyc(); chk_b("b_green3", 4'b1000, 4'b0000, 10, 2'd3);
    cyc(); chk_b("b_empty3", 4'b0000, 4'b1000, 3, 2'd3);
    cyc(); chk_b("b_yellow3", 4'b0000, 4'b1000, 2, 2'd3);
    cyc(); chk_b("b_yellow3", 4'b0000, 4'b1000, 1, 2'd3);
    cyc(); chk_b("b_wrap_to0", 4'b0001, 4'b0000, 12, 2'd0);
    // Only the current approach waits: it is re-selected
    for (int d = 11; d >= 1; d--) begin cyc(); chk_b("b_green0_b", 4'b0001, 4'b0000, d, 2'd0); end
    for (int d = 3; d >= 1; d--)  begin cyc(); chk_b("b_yellow0_b", 4'b0000, 4'b0001, d, 2'd0); end
    cyc(); chk_b("b_self_last", 4'b0001, 4'b0000, 12, 2'd0);

    cyc(); cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
